serialize: RTL and testbench

SERIALIZE -- requirements
Module: serialize

---
 rtl/serialize.sv | 115 +++++++++++
 tb/tb_serialize.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serialize.sv
// Word-to-dibit serializer: a one-word skid buffer feeds a 32-bit shift register
// that emits 16 dibits MSB-first per word, with an enforced inter-packet gap.
module serialize #(
    parameter int IFG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [31:0] axiid,
    input  logic        axiil,
    output logic        axiir,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic        underrun,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_INIT = 4'(IFG - 1);

    state_t      r_state;
    logic [31:0] r_buf_data;
    logic        r_buf_last;
    logic        r_buf_full;
    logic [31:0] r_shift;
    logic        r_cur_last;
    logic [3:0]  r_cnt;
    logic [3:0]  r_gap;

    logic        w_accept;
    logic        w_load;
    logic        w_word_end;

    // Ready depends only on registered state; gated low while reset is held.
    assign axiir      = rst & ~r_buf_full;
    assign busy       = (r_state != IDLE) | r_buf_full;
    assign w_accept   = axiiv & axiir;
    assign w_word_end = (r_state == SHIFT) && (r_cnt == 4'd15);

    assign w_load = r_buf_full &
                    ((r_state == IDLE) ||
                     (w_word_end && !r_cur_last) ||
                     ((r_state == GAP) && (r_gap == 4'd0)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_buf_data <= '0;
            r_buf_last <= 1'b0;
            r_buf_full <= 1'b0;
            r_shift    <= '0;
            r_cur_last <= 1'b0;
            r_cnt      <= '0;
            r_gap      <= '0;
            axiov      <= 1'b0;
            axiod      <= 2'b00;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;

            // Accept requires an empty buffer and load requires a full one,
            // so both can never happen in the same cycle.
            if (w_load) begin
                r_buf_full <= 1'b0;
            end else if (w_accept) begin
                r_buf_full <= 1'b1;
                r_buf_data <= axiid;
                r_buf_last <= axiil;
            end

            if (w_load) begin
                r_state    <= SHIFT;
                r_shift    <= {r_buf_data[29:0], 2'b00};
                r_cur_last <= r_buf_last;
                r_cnt      <= 4'd0;
                axiov      <= 1'b1;
                axiod      <= r_buf_data[31:30];
            end else begin
                case (r_state)
                    SHIFT: begin
                        if (!w_word_end) begin
                            r_cnt   <= r_cnt + 4'd1;
                            r_shift <= {r_shift[29:0], 2'b00};
                            axiod   <= r_shift[31:30];
                        end else begin
                            // Reached only when the word is last or nothing is buffered.
                            r_state  <= GAP;
                            r_gap    <= GAP_INIT;
                            r_cnt    <= 4'd0;
                            axiov    <= 1'b0;
                            axiod    <= 2'b00;
                            underrun <= ~r_cur_last;
                        end
                    end
                    GAP: begin
                        if (r_gap == 4'd0) begin
                            r_state <= IDLE;
                        end else begin
                            r_gap <= r_gap - 4'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serialize.sv
// Scoreboard bench for serialize: words are queued at handshake and a monitor
// reassembles 16 dibits per word, checking data, gaps and underrun pulses.
module tb_serialize;

    localparam int IFG = 2;

    logic        clk;
    logic        rst;
    logic        axiiv;
    logic [31:0] axiid;
    logic        axiil;
    logic        axiir;
    logic        axiov;
    logic [1:0]  axiod;
    logic        underrun;
    logic        busy;

    serialize #(.IFG(IFG)) dut (
        .clk      (clk),
        .rst      (rst),
        .axiiv    (axiiv),
        .axiid    (axiid),
        .axiil    (axiil),
        .axiir    (axiir),
        .axiov    (axiov),
        .axiod    (axiod),
        .underrun (underrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        ur;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Monitor state.
    int          mon_n      = 0;
    int          zeros      = 0;
    int          run        = 0;
    int          last_run   = 0;
    int          last_gap   = 0;
    int          words_done = 0;
    int          ur_count   = 0;
    int          prev_kind  = 0;   // 0 none, 1 contiguous word follows, 2 packet ended
    logic        ur_due     = 1'b0;
    logic [31:0] acc        = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_n     = 0;
            zeros     = 0;
            run       = 0;
            prev_kind = 0;
            ur_due    = 1'b0;
        end else begin
            if (underrun) ur_count++;
            if (underrun || ur_due) chk("underrun_pulse", 32'(underrun), 32'(ur_due));
            ur_due = 1'b0;
            if (axiov) begin
                if (mon_n == 0) begin
                    if (prev_kind == 1) chk("no_bubble", 32'(zeros), 32'd0);
                    if (prev_kind == 2) begin
                        chk("gap_min", 32'(zeros >= IFG), 32'd1);
                        last_gap = zeros;
                    end
                end
                zeros = 0;
                acc   = {acc[29:0], axiod};
                mon_n++;
                run++;
                if (mon_n == 16) begin
                    mon_n = 0;
                    words_done++;
                    if (sb.size() == 0) begin
                        chk("unexpected_word", acc, 32'hxxxxxxxx);
                        prev_kind = 2;
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("word_data", acc, e.d);
                        ur_due    = e.ur;
                        prev_kind = (e.l || e.ur) ? 2 : 1;
                    end
                end
            end else begin
                chk("idle_dibit", 32'(axiod), 32'd0);
                if (mon_n != 0) chk("partial_word", 32'(mon_n), 32'd0);
                mon_n = 0;
                if (run != 0) last_run = run;
                run = 0;
                zeros++;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l, input logic ur);
        int t = 0;
        axiiv = 1'b1;
        axiid = d;
        axiil = l;
        while (!axiir && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("send_ready", 32'(axiir), 32'd1);
        if (axiir) begin
            @(posedge clk);
            sb.push_back('{d: d, l: l, ur: ur});
            #1;
        end
        axiiv = 1'b0;
        axiid = '0;
        axiil = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || busy || axiov) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 32'(t < 3000), 32'd1);
        repeat (IFG + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        int          ur0;
        int          wd0;
        int          t;
        int          sent;

        rst   = 1'b0;
        axiiv = 1'b0;
        axiid = '0;
        axiil = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_axiov", 32'(axiov), 32'd0);
        chk("rst_axiod", 32'(axiod), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_axiir", 32'(axiir), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        #1;
        chk("release_axiir", 32'(axiir), 32'd1);
        @(posedge clk);
        #1;

        // Single word: latency and per-dibit order.
        w = 32'hDEADBEEF;
        send(w, 1'b1, 1'b0);
        chk("pre_load_axiov", 32'(axiov), 32'd0);
        chk("full_axiir", 32'(axiir), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            chk("single_axiov", 32'(axiov), 32'd1);
            chk("single_dibit", 32'(axiod), 32'((w >> (30 - 2 * i)) & 32'd3));
        end
        for (int g = 0; g < IFG; g++) begin
            @(posedge clk);
            #1;
            chk("single_gap", 32'(axiov), 32'd0);
        end
        wait_idle();

        // Back-to-back words in one packet.
        ur0 = ur_count;
        send(32'h12345678, 1'b0, 1'b0);
        send(32'h9ABCDEF0, 1'b1, 1'b0);
        wait_idle();
        chk("b2b_run", 32'(last_run), 32'd32);
        chk("b2b_no_underrun", 32'(ur_count - ur0), 32'd0);

        // Underrun: non-last word with nothing behind it.
        ur0 = ur_count;
        send(32'hFFFFFFFF, 1'b0, 1'b1);
        wait_idle();
        chk("ur_pulses", 32'(ur_count - ur0), 32'd1);
        chk("ur_run", 32'(last_run), 32'd16);

        // Gap enforcement between two single-word packets.
        send(32'h0F0F1234, 1'b1, 1'b0);
        send(32'hCAFEF00D, 1'b1, 1'b0);
        chk("waiting_axiir", 32'(axiir), 32'd0);
        chk("waiting_busy", 32'(busy), 32'd1);
        wait_idle();
        chk("gap_exact", 32'(last_gap), 32'(IFG));

        // Reset mid-packet with a second word buffered.
        wd0 = words_done;
        send(32'hC0FFEE11, 1'b0, 1'b0);
        send(32'h77665544, 1'b1, 1'b0);
        t = 0;
        while (mon_n != 7 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("reach_dibit7", 32'(mon_n), 32'd7);
        @(posedge clk);
        #2;
        chk("mid_axiov", 32'(axiov), 32'd1);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("async_axiov", 32'(axiov), 32'd0);
        chk("async_axiod", 32'(axiod), 32'd0);
        chk("async_axiir", 32'(axiir), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rerelease_axiir", 32'(axiir), 32'd1);
        chk("rerelease_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        send(32'h5A5AF00D, 1'b1, 1'b0);
        wait_idle();
        chk("post_reset_words", 32'(words_done - wd0), 32'd1);

        // Randomized loopback: 100 words in packets of 1..4 words.
        wd0  = words_done;
        ur0  = ur_count;
        sent = 0;
        while (sent < 100) begin
            int plen;
            plen = $urandom_range(1, 4);
            if (sent + plen > 100) plen = 100 - sent;
            for (int k = 0; k < plen; k++) begin
                send($urandom, (k == plen - 1) ? 1'b1 : 1'b0, 1'b0);
            end
            sent += plen;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end
        wait_idle();
        chk("loop_words", 32'(words_done - wd0), 32'd100);
        chk("loop_no_underrun", 32'(ur_count - ur0), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
